// File: rtl/arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   arb_state_e : FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   PORT0/PORT1 : requester index constants used for owner/last tracking
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin pick between two level requests.
//   req0, req1 : in  request lines
//   last       : in  index of the port served most recently
//   valid      : out at least one request present
//   winner     : out index of the granted port (meaningful when valid)
module arb_rr_select
  import arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = PORT0;
    if (req0 && req1) begin
      // On a tie the port that did not go last wins, giving strict alternation.
      winner = ~last;
    end else if (req1) begin
      winner = PORT1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two
// requesters. One memory cycle per grant; a one-cycle ack returns completion
// and, for reads, the registered read data.
//   Clock, reset            : clock, synchronous active-high reset
//   req*/wr*/addr*/wdata*   : per-port level request, direction, address, data
//   ack0, ack1              : one-cycle completion pulse for the owner
//   rdata                   : last captured read data
//   gnt0, gnt1              : owner indication from ISSUE through RESP
//   busy                    : FSM not in IDLE
//   mem_addr/mem_wdata/mem_wr/mem_en/mem_rdata : memory side
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic sel_valid;
  logic sel_winner;

  arb_rr_select u_sel (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .valid  (sel_valid),
    .winner (sel_winner)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          owner_d = sel_winner;
          wr_d    = sel_winner ? wr1    : wr0;
          addr_d  = sel_winner ? addr1  : addr0;
          wdata_d = sel_winner ? wdata1 : wdata0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = wr_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        // cnt_q reaches zero in the last WAIT cycle, when mem_rdata is valid.
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= PORT0;
      last_q  <= PORT1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign gnt0      = busy && (owner_q == PORT0);
  assign gnt1      = busy && (owner_q == PORT1);
  assign ack0      = (state_q == ST_RESP) && (owner_q == PORT0);
  assign ack1      = (state_q == ST_RESP) && (owner_q == PORT1);
  assign mem_en    = (state_q == ST_ISSUE);
  // A write whose ISSUE cycle meets reset must not reach the memory.
  assign mem_wr    = mem_en & wr_q & ~reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  typedef struct {
    bit          port;
    bit          rd;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks;
  int   failures;
  exp_t q_a[$];
  exp_t q_b[$];
  int   cur;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        ack0_a, ack1_a, gnt0_a, gnt1_a, busy_a, mem_wr_a, mem_en_a;
  logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        ack0_b, ack1_b, gnt0_b, gnt1_b, busy_b, mem_wr_b, mem_en_b;
  logic [15:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .READ_LAT(LAT_A)) dut_a (
    .Clock(clk), .reset(rst_a),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_a), .ack1(ack1_a), .rdata(rdata_a),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .busy(busy_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wr(mem_wr_a),
    .mem_en(mem_en_a), .mem_rdata(mem_rdata_a)
  );

  mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .READ_LAT(LAT_B)) dut_b (
    .Clock(clk), .reset(rst_b),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .busy(busy_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wr(mem_wr_b),
    .mem_en(mem_en_b), .mem_rdata(mem_rdata_b)
  );

  // Memory models with READ_LAT-deep read pipelines.
  bit [15:0] mem_a [256];
  bit [15:0] pipe_a [LAT_A];
  always @(posedge clk) begin
    if (mem_en_a && mem_wr_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
    pipe_a[0] <= mem_a[mem_addr_a[7:0]];
    for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign mem_rdata_a = pipe_a[LAT_A-1];

  bit [15:0] mem_b [256];
  bit [15:0] pipe_b [LAT_B];
  always @(posedge clk) begin
    if (mem_en_b && mem_wr_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
    pipe_b[0] <= mem_b[mem_addr_b[7:0]];
    for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign mem_rdata_b = pipe_b[LAT_B-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_ack(input string t, input exp_t e, input logic a0, input logic a1,
                           input logic g0, input logic g1, input logic [15:0] rd);
    chk({t, "_ack_both"}, 32'(a0 & a1), 32'd0);
    chk({t, "_ack_port"}, 32'(a1), 32'(e.port));
    chk({t, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
    chk({t, "_gnt_owner"}, 32'({g1, g0}), e.port ? 32'd2 : 32'd1);
    if (e.rd) chk({t, "_rdata"}, 32'(rd), 32'(e.rdata));
  endtask

  // Monitors: pop the scoreboard whenever an ack appears.
  always @(negedge clk) begin
    if (ack0_a || ack1_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_ack ack0=%0b ack1=%0b required=no ack (cycle %0d)",
                 ack0_a, ack1_a, cyc);
      end else begin
        check_ack("a", q_a.pop_front(), ack0_a, ack1_a, gnt0_a, gnt1_a, rdata_a);
      end
    end
  end

  always @(negedge clk) begin
    if (ack0_b || ack1_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_ack ack0=%0b ack1=%0b required=no ack (cycle %0d)",
                 ack0_b, ack1_b, cyc);
      end else begin
        check_ack("b", q_b.pop_front(), ack0_b, ack1_b, gnt0_b, gnt1_b, rdata_b);
      end
    end
  end

  task automatic set_port(input bit p, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
    if (p) begin
      req1 = r; wr1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; wr0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic push(input bit p, input bit rd, input logic [15:0] rdv, input int c);
    exp_t e;
    e.port  = p;
    e.rd    = rd;
    e.rdata = rdv;
    e.cyc   = c;
    if (cur == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  // Raise a request; ack expected 2 cycles later for a write, 2+READ_LAT for a read.
  task automatic issue(input bit p, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input bit expect_ack);
    int lat;
    @(posedge clk); #1;
    set_port(p, 1'b1, w, a, d);
    lat = (cur == 0) ? LAT_A : LAT_B;
    if (expect_ack) push(p, !w, exp_rd, cyc + 2 + (w ? 0 : lat));
  endtask

  // Wait (bounded) for the port's ack, then drop its request on the edge that samples it.
  task automatic wait_ack(input bit p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cur == 0) seen = p ? ack1_a : ack0_a;
      else          seen = p ? ack1_b : ack0_b;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_ack port%0d actual=no ack required=ack within 40 cycles", p);
    end
    @(posedge clk); #1;
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    cur = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", 32'(ack0_a), 32'd0);
    chk("rst_ack1", 32'(ack1_a), 32'd0);
    chk("rst_gnt", 32'({gnt1_a, gnt0_a}), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_mem_en", 32'(mem_en_a), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr_a), 32'd0);
    chk("rst_rdata", 32'(rdata_a), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata_a), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);

    // Tie from reset with both held: order 0,1,0,1, one write every 3 cycles.
    @(posedge clk); #1;
    rst_a = 1'b0;
    set_port(1'b0, 1'b1, 1'b1, 16'h0040, 16'h1111);
    set_port(1'b1, 1'b1, 1'b1, 16'h0041, 16'h2222);
    k = cyc;
    push(1'b0, 1'b0, 16'h0, k + 2);
    push(1'b1, 1'b0, 16'h0, k + 5);
    push(1'b0, 1'b0, 16'h0, k + 8);
    push(1'b1, 1'b0, 16'h0, k + 11);
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (ack0_a || ack1_a) n++;
    end
    chk("tie_ack_count", 32'(n), 32'd4);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;

    // Single write with the port address changed during ISSUE.
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b1);
    @(posedge clk); #1;
    addr0 = 16'h0020;
    @(negedge clk);
    chk("wr_issue_mem_en", 32'(mem_en_a), 32'd1);
    chk("wr_issue_mem_wr", 32'(mem_wr_a), 32'd1);
    chk("wr_issue_mem_addr", 32'(mem_addr_a), 32'h0010);
    chk("wr_issue_mem_wdata", 32'(mem_wdata_a), 32'hBEEF);
    wait_ack(1'b0);

    issue(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b1);
    wait_ack(1'b1);
    issue(1'b0, 1'b0, 16'h0020, 16'h0, 16'h0000, 1'b1);
    wait_ack(1'b0);
    issue(1'b1, 1'b1, 16'h0030, 16'h1234, 16'h0, 1'b1);
    wait_ack(1'b1);

    // Reset during the ISSUE cycle of a write: no commit, no ack.
    issue(1'b0, 1'b1, 16'h0030, 16'hDEAD, 16'h0, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    chk("rstmid_mem_wr", 32'(mem_wr_a), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    req0  = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy_a), 32'd0);
    chk("rstmid_gnt", 32'({gnt1_a, gnt0_a}), 32'd0);
    chk("rstmid_ack", 32'({ack1_a, ack0_a}), 32'd0);
    chk("rstmid_mem_en", 32'(mem_en_a), 32'd0);
    chk("rstmid_rdata", 32'(rdata_a), 32'd0);
    chk("rstmid_mem_addr", 32'(mem_addr_a), 32'd0);
    chk("rstmid_mem_wdata", 32'(mem_wdata_a), 32'd0);

    // Tie of reads after reset: port 0 first (last=1), reads 4 cycles apart.
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
    set_port(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
    k = cyc;
    push(1'b0, 1'b1, 16'h1234, k + 3);
    push(1'b1, 1'b1, 16'hBEEF, k + 7);
    wait_ack(1'b0);
    wait_ack(1'b1);

    // READ_LAT=3 instance.
    @(posedge clk); #1;
    rst_a = 1'b1;
    rst_b = 1'b0;
    cur   = 1;
    issue(1'b0, 1'b1, 16'h0005, 16'hCAFE, 16'h0, 1'b1);
    wait_ack(1'b0);
    issue(1'b1, 1'b0, 16'h0005, 16'h0, 16'hCAFE, 1'b1);
    wait_ack(1'b1);
    issue(1'b0, 1'b0, 16'h0006, 16'h0, 16'h0000, 1'b1);
    wait_ack(1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
